alu_issuer: RTL and testbench

ALU_ISSUER -- requirements
Module: alu_issuer

---
 rtl/alu_pkg.sv | 10 +
 rtl/alu.sv | 46 ++++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/alu_issuer.sv | 110 +++++++++++
 tb/tb_alu_issuer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared operation encoding for the ALU and its issuer
package alu_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } operation_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - two-stage add/sub ALU without backpressure
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  operation_t       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] s1_res;
  logic             s1_valid;
  logic [WIDTH-1:0] res;

  // Result wraps at WIDTH bits; nop yields zero.
  always_comb begin
    res = '0;
    case (op_in)
      OP_ADD:  res = a_in + b_in;
      OP_SUB:  res = a_in - b_in;
      default: res = '0;
    endcase
  end

  // Two register stages give a fixed two-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_res    <= '0;
      s1_valid  <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      s1_res    <= in_valid ? res : '0;
      s1_valid  <= in_valid;
      out       <= s1_res;
      out_valid <= s1_valid;
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous result buffer with show-ahead read data
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // A write into a full buffer is allowed when the same edge frees a slot.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Storage array needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap explicitly at DEPTH-1; occupancy follows write/read pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - credit-based command issue to a fixed-latency ALU
module alu_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  operation_t       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output operation_t       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_in_valid,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_out_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credits_used;
  logic          fifo_full;
  logic          fifo_empty;
  logic          handshake;
  logic          rsp_take;
  logic          drop;
  logic          buf_wr;
  logic          inflight_dec;

  // Credits: every command in the ALU or waiting in the buffer owns a slot.
  assign credits_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign cmd_ready    = (credits_used < (CW + 1)'(DEPTH));
  assign handshake    = cmd_valid && cmd_ready;

  assign rsp_valid    = !fifo_empty;
  assign rsp_take     = rsp_valid && rsp_ready;

  // Results with no outstanding command, or with nowhere to go, are dropped.
  assign drop         = alu_out_valid && ((inflight == '0) || (fifo_full && !rsp_take));
  assign buf_wr       = alu_out_valid && !drop;
  assign inflight_dec = alu_out_valid && (inflight != '0);

  // Issue register: one-cycle pulse carrying the accepted command, idle zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in_valid <= 1'b0;
      alu_op       <= OP_NOP;
      alu_a        <= '0;
      alu_b        <= '0;
    end else if (handshake) begin
      alu_in_valid <= 1'b1;
      alu_op       <= cmd_op;
      alu_a        <= cmd_a;
      alu_b        <= cmd_b;
    end else begin
      alu_in_valid <= 1'b0;
      alu_op       <= OP_NOP;
      alu_a        <= '0;
      alu_b        <= '0;
    end
  end

  // In-flight counter: up on accept, down on a returned result, saturating at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({handshake, inflight_dec})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (drop) begin
      err <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_wr),
    .wr_data (alu_out),
    .rd_en   (rsp_take),
    .rd_data (rsp_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_alu_issuer.sv
// tb/tb_alu_issuer.sv - scoreboard bench for alu_issuer with the ALU downstream
module tb_alu_issuer;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  operation_t cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  operation_t alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_in_valid;
  logic [7:0] alu_res;
  logic       alu_res_valid;
  logic [7:0] alu_out;
  logic       alu_out_valid;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       err;
  logic       inj_valid;
  logic [7:0] inj_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  assign alu_out_valid = alu_res_valid | inj_valid;
  assign alu_out       = inj_valid ? inj_data : alu_res;

  alu_issuer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .alu_op        (alu_op),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_in_valid  (alu_in_valid),
    .alu_out       (alu_out),
    .alu_out_valid (alu_out_valid),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .err           (err)
  );

  alu #(.WIDTH(8)) u_alu (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_in     (alu_op),
    .a_in      (alu_a),
    .b_in      (alu_b),
    .in_valid  (alu_in_valid),
    .out       (alu_res),
    .out_valid (alu_res_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every response handshake is compared with the oldest expectation.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual=%0h required=none", rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e));
        end
      end
    end
  end

  task automatic send(input operation_t op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=cmd_ready_low required=accept");
        cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    cmd_valid = 1'b0;
    cmd_op = OP_NOP;
    cmd_a = '0;
    cmd_b = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Holds cmd_valid for a number of cycles, incrementing cmd_a per accept.
  task automatic stream(input int cycles, input int rv_checks, output int acc);
    logic hs;
    acc = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      hs = cmd_ready;
      if (i < rv_checks) check("sustain_rsp_valid", 32'(rsp_valid), 32'd1);
      @(posedge clk);
      if (hs) begin
        exp_q.push_back((cmd_op == OP_SUB) ? cmd_a - cmd_b : cmd_a + cmd_b);
        acc++;
      end
      #1;
      if (hs) cmd_a = cmd_a + 8'd1;
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int acc;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = OP_NOP;
    cmd_a = '0;
    cmd_b = '0;
    rsp_ready = 1'b1;
    inj_valid = 1'b0;
    inj_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_in_valid", 32'(alu_in_valid), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add 3,5: issue pulse, then response three edges after acceptance
    send(OP_ADD, 8'd3, 8'd5, 8'h08);
    check("issue_valid", 32'(alu_in_valid), 32'd1);
    check("issue_op", 32'(alu_op), 32'(OP_ADD));
    check("issue_a", 32'(alu_a), 32'd3);
    check("issue_b", 32'(alu_b), 32'd5);
    @(posedge clk); #1;
    check("issue_pulse_end", 32'(alu_in_valid), 32'd0);
    check("idle_op_nop", 32'(alu_op), 32'(OP_NOP));
    check("idle_a_zero", 32'(alu_a), 32'd0);
    check("lat_edge1", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge2", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge3", 32'(rsp_valid), 32'd1);
    drain();

    // back-to-back sub, wrapping add, nop
    send(OP_SUB, 8'd5, 8'd7, 8'hFE);
    send(OP_ADD, 8'hFF, 8'h01, 8'h00);
    send(OP_NOP, 8'd9, 8'd9, 8'h00);
    drain();

    // credit exhaustion with rsp_ready low
    rsp_ready = 1'b0;
    cmd_op = OP_ADD;
    cmd_a = 8'h10;
    cmd_b = 8'h01;
    stream(12, 0, acc);
    check("credit_accepts", 32'(acc), 32'd4);
    check("credit_ready_low", 32'(cmd_ready), 32'd0);
    check("rsp_hold_oldest", 32'(rsp_data), 32'h11);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("credit_ready_back", 32'(cmd_ready), 32'd1);
    cmd_op = OP_ADD;
    cmd_b = 8'h01;
    stream(8, 0, acc);
    check("credit_one_more", 32'(acc), 32'd1);
    check("credit_ready_low2", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    drain();

    // full buffer drained while accepting continuously
    rsp_ready = 1'b0;
    send(OP_ADD, 8'd1, 8'd1, 8'd2);
    send(OP_ADD, 8'd2, 8'd2, 8'd4);
    send(OP_ADD, 8'd3, 8'd3, 8'd6);
    send(OP_ADD, 8'd4, 8'd4, 8'd8);
    repeat (6) @(posedge clk);
    #1;
    check("full_ready_low", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    cmd_op = OP_SUB;
    cmd_a = 8'h40;
    cmd_b = 8'h03;
    stream(16, 4, acc);
    check("full_stream_accepts", 32'(acc > 8), 32'd1);
    drain();
    check("full_stream_err", 32'(err), 32'd0);

    // reset with two in flight and two buffered
    rsp_ready = 1'b0;
    send(OP_ADD, 8'd10, 8'd1, 8'd11);
    send(OP_ADD, 8'd20, 8'd1, 8'd21);
    send(OP_ADD, 8'd30, 8'd1, 8'd31);
    send(OP_ADD, 8'd40, 8'd1, 8'd41);
    @(posedge clk); #1;
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_alu_in_valid", 32'(alu_in_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // stray result with nothing in flight
    inj_data = 8'h55;
    inj_valid = 1'b1;
    @(posedge clk); #1;
    inj_valid = 1'b0;
    check("stray_err_set", 32'(err), 32'd1);
    check("stray_dropped", 32'(rsp_valid), 32'd0);
    check("stray_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("stray_err_sticky", 32'(err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
